multip_2bit: RTL and testbench

- 2x2-bit unsigned multiplier built on the Vedic Urdhva-Tiryakbhyam (vertical and crosswise) structure from two half adders.
- Output is registered.
- Leaf arithmetic block used as the base cell for larger Vedic multipliers (4/8/16-bit trees) and as a standalone small-product unit.
- Single clock domain; asynchronous active-low reset.

---
 rtl/multip_2bit.sv | 130 +++++++++++++
 tb/tb_multip_2bit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/multip_2bit.sv
// multip_2bit: 2x2-bit unsigned Vedic (Urdhva-Tiryakbhyam) multiplier.
// The vertical/crosswise partial products are combined with two half adders.
// The product is registered, and an optional input register stage adds one
// cycle of latency. The valid flag travels alongside the data through every stage.

// Half adder leaf cell: sum = x ^ y, carry = x & y.
module multip_2bit_ha (
  input  logic x,
  input  logic y,
  output logic sum,
  output logic carry
);

  assign sum   = x ^ y;
  assign carry = x & y;

endmodule

module multip_2bit #(
  parameter int IN_REG = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       in_valid,
  output logic [3:0] q,
  output logic       out_valid
);

  // Operands and valid flag as seen by the arithmetic core.
  logic [1:0] coreA;
  logic [1:0] coreB;
  logic       coreValid;

  generate
    if (IN_REG != 0) begin : gInReg
      logic [1:0] opA_q;
      logic [1:0] opB_q;
      logic       opValid_q;

      // Input stage: capture the operands together with their valid flag so both stay aligned.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          opA_q     <= 2'b00;
          opB_q     <= 2'b00;
          opValid_q <= 1'b0;
        end else begin
          opA_q     <= a;
          opB_q     <= b;
          opValid_q <= in_valid;
        end
      end

      assign coreA     = opA_q;
      assign coreB     = opB_q;
      assign coreValid = opValid_q;
    end else begin : gNoInReg
      assign coreA     = a;
      assign coreB     = b;
      assign coreValid = in_valid;
    end
  endgenerate

  // Vertical and crosswise partial products.
  logic p0;
  logic crossHi;
  logic crossLo;
  logic vertHi;

  assign p0      = coreA[0] & coreB[0];
  assign crossHi = coreA[1] & coreB[0];
  assign crossLo = coreA[0] & coreB[1];
  assign vertHi  = coreA[1] & coreB[1];

  // Half-adder outputs.
  logic s1;
  logic c1;
  logic s2;
  logic c2;

  // The crosswise terms meet in the middle column.
  multip_2bit_ha uHa1 (
    .x     (crossHi),
    .y     (crossLo),
    .sum   (s1),
    .carry (c1)
  );

  // The middle-column carry ripples into the vertical high term.
  multip_2bit_ha uHa2 (
    .x     (vertHi),
    .y     (c1),
    .sum   (s2),
    .carry (c2)
  );

  logic [3:0] coreProduct;
  assign coreProduct = {c2, s2, s1, p0};

  // Output registers and their next-state values.
  logic [3:0] prod_q;
  logic [3:0] prod_d;
  logic       valid_q;
  logic       valid_d;

  // Next-state logic: load a new product only when it is valid, otherwise keep the last one.
  always_comb begin
    prod_d  = prod_q;
    valid_d = coreValid;
    if (coreValid) begin
      prod_d = coreProduct;
    end
  end

  // Output register: the reset clears the product and the valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= 4'b0000;
      valid_q <= 1'b0;
    end else begin
      prod_q  <= prod_d;
      valid_q <= valid_d;
    end
  end

  assign q         = prod_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_multip_2bit.sv
// tb_multip_2bit: checks two instances of multip_2bit (IN_REG=0 and IN_REG=1)
// against a model of "product = a*b, delivered after a fixed latency".
`timescale 1ns/1ps

module tb_multip_2bit;

  logic       clk;
  logic       rst_n;
  logic [1:0] a;
  logic [1:0] b;
  logic       in_valid;
  logic [3:0] q0;
  logic       outValid0;
  logic [3:0] q1;
  logic       outValid1;

  int checksTotal  = 0;
  int checksPassed = 0;

  // Model state: per-edge history of the offered operand pair.
  // An entry is visible for latency L at the edge L-1 edges later,
  // and only if it was sampled after the most recent reset.
  bit histValid[$];
  int histProd[$];
  int resetMark = 0;
  int lastProd[2];
  int expProd[2];
  bit expValid[2];

  multip_2bit #(.IN_REG(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .q         (q0),
    .out_valid (outValid0)
  );

  multip_2bit #(.IN_REG(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .q         (q1),
    .out_valid (outValid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checksTotal++;
    assert (observed === expected) checksPassed++;
    else $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
  endtask

  // Update the model for one clock edge and compare both instances.
  task automatic modelAndCheck(input string tag);
    int k;
    int idx;
    k = histValid.size() - 1;
    for (int lat = 1; lat <= 2; lat++) begin
      idx = k - (lat - 1);
      if (idx >= resetMark && histValid[idx]) begin
        lastProd[lat-1] = histProd[idx];
        expValid[lat-1] = 1'b1;
      end else begin
        expValid[lat-1] = 1'b0;
      end
      expProd[lat-1] = lastProd[lat-1];
    end
    checkOutput({tag, " q L1"}, q0, 4'(expProd[0]));
    checkOutput({tag, " valid L1"}, {3'b000, outValid0}, {3'b000, expValid[0]});
    checkOutput({tag, " q L2"}, q1, 4'(expProd[1]));
    checkOutput({tag, " valid L2"}, {3'b000, outValid1}, {3'b000, expValid[1]});
  endtask

  // Drive one operand pair, clock it in, then check slightly after the edge.
  task automatic applyStimulus(input string tag, input int av, input int bv, input bit v);
    a        = 2'(av);
    b        = 2'(bv);
    in_valid = v;
    @(posedge clk);
    histValid.push_back(v);
    histProd.push_back(av * bv);
    #1;
    modelAndCheck(tag);
  endtask

  // Assert reset between edges, check the asynchronous clear, then release between edges.
  task automatic applyReset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput({tag, " async q L1"}, q0, 4'b0000);
    checkOutput({tag, " async valid L1"}, {3'b000, outValid0}, 4'b0000);
    checkOutput({tag, " async q L2"}, q1, 4'b0000);
    checkOutput({tag, " async valid L2"}, {3'b000, outValid1}, 4'b0000);
    resetMark   = histValid.size();
    lastProd[0] = 0;
    lastProd[1] = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int ra;
    int rb;
    rst_n    = 1'b0;
    a        = 2'd0;
    b        = 2'd0;
    in_valid = 1'b0;
    lastProd[0] = 0;
    lastProd[1] = 0;
    $display("[TB] start");

    #1;
    checkOutput("por q L1", q0, 4'b0000);
    checkOutput("por valid L1", {3'b000, outValid0}, 4'b0000);
    checkOutput("por q L2", q1, 4'b0000);
    checkOutput("por valid L2", {3'b000, outValid1}, 4'b0000);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);

    // Exhaustive sweep with valid every cycle.
    for (int i = 0; i < 16; i++) begin
      applyStimulus($sformatf("sweep %0dx%0d", i / 4, i % 4), i / 4, i % 4, 1'b1);
    end
    applyStimulus("sweep tail", 0, 0, 1'b0);
    checkOutput("sweep 3x3 final L2", q1, 4'b1001);

    // Reset with 3x3 loaded, then idle after release.
    applyStimulus("load 3x3", 3, 3, 1'b1);
    applyStimulus("load 3x3 b", 3, 3, 1'b1);
    applyReset("rst");
    applyStimulus("post rst idle", 3, 3, 1'b0);
    applyStimulus("post rst idle b", 3, 3, 1'b0);
    checkOutput("post rst q stays 0", q0, 4'b0000);

    // Hold behaviour: one valid pair, then invalid inputs must not disturb q.
    applyStimulus("hold 2x3", 2, 3, 1'b1);
    checkOutput("hold 2x3 direct", q0, 4'b0110);
    applyStimulus("hold idle 1", 1, 1, 1'b0);
    applyStimulus("hold idle 2", 1, 1, 1'b0);
    checkOutput("hold q kept", q0, 4'b0110);

    // Mid-flight reset for the input-registered instance.
    applyStimulus("flight 3x2", 3, 2, 1'b1);
    applyReset("flight rst");
    applyStimulus("flight after 1", 0, 0, 1'b0);
    applyStimulus("flight after 2", 0, 0, 1'b0);
    checkOutput("flight no pulse", {3'b000, outValid1}, 4'b0000);
    checkOutput("flight q zero", q1, 4'b0000);

    // Latency of the input-registered instance.
    applyStimulus("lat idle", 0, 0, 1'b0);
    applyStimulus("lat 3x3 edge N", 3, 3, 1'b1);
    checkOutput("lat not before", {3'b000, outValid1}, 4'b0000);
    applyStimulus("lat edge N+1", 0, 0, 1'b0);
    checkOutput("lat q N+1", q1, 4'b1001);
    checkOutput("lat valid N+1", {3'b000, outValid1}, 4'b0001);

    // Back-to-back stream.
    applyStimulus("b2b 1x1", 1, 1, 1'b1);
    checkOutput("b2b q0 1", q0, 4'b0001);
    applyStimulus("b2b 3x2", 3, 2, 1'b1);
    checkOutput("b2b q0 2", q0, 4'b0110);
    applyStimulus("b2b 2x2", 2, 2, 1'b1);
    checkOutput("b2b q0 3", q0, 4'b0100);
    applyStimulus("b2b 3x3", 3, 3, 1'b1);
    checkOutput("b2b q0 4", q0, 4'b1001);
    applyStimulus("b2b drain", 0, 0, 1'b0);
    checkOutput("b2b q1 4", q1, 4'b1001);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      ra = int'($urandom_range(0, 3));
      rb = int'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) begin
        applyReset($sformatf("rand rst %0d", i));
      end
      applyStimulus($sformatf("rand %0d", i), ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
